// File: rtl/dmem_pkg.sv
// Shared encodings and the access fault check for the MEM-stage data memory.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    function automatic logic access_fault(
        input logic [1:0]  size,
        input logic [31:0] addr,
        input logic [31:0] depth
    );
        logic f;
        f = 1'b0;
        unique case (size)
            SZ_BYTE: f = 1'b0;
            SZ_HALF: f = addr[0];
            SZ_WORD: f = |addr[1:0];
            default: f = 1'b1;
        endcase
        if (addr >= depth) begin
            f = 1'b1;
        end
        return f;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Picks the addressed byte/half/word out of four raw bytes and extends it.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);

    logic [31:0] sh;

    always_comb begin
        sh     = raw_i >> {off_i, 3'b000};
        data_o = sh;
        unique case (size_i)
            SZ_BYTE: data_o = {{24{signed_i & sh[7]}}, sh[7:0]};
            SZ_HALF: data_o = {{16{signed_i & sh[15]}}, sh[15:0]};
            default: data_o = sh;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Byte-addressed data memory with valid/ready requests and a fixed-latency
// single-outstanding response.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = $clog2(LATENCY) + 1;

    logic [7:0] mem_q [DEPTH_BYTES];

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   pend_raw_q, pend_raw_d;
    logic [1:0]    pend_size_q, pend_size_d;
    logic [1:0]    pend_off_q, pend_off_d;
    logic          pend_signed_q, pend_signed_d;
    logic          pend_write_q, pend_write_d;
    logic          pend_err_q, pend_err_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;

    logic          accept;
    logic          fault;
    logic          we;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   rd_raw;
    logic [31:0]   aligned;
    logic [AW-3:0] word_idx;

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;

    assign accept   = req_valid_i & req_ready_o;
    assign fault    = access_fault(req_size_i, addr_i, 32'(DEPTH_BYTES));
    assign word_idx = addr_i[AW-1:2];

    // Lanes are word-aligned; the offset shifts data and enables into place.
    always_comb begin
        be = 4'b0000;
        unique case (req_size_i)
            SZ_BYTE: be = 4'b0001 << addr_i[1:0];
            SZ_HALF: be = 4'b0011 << addr_i[1:0];
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        wdata = write_data_i << {addr_i[1:0], 3'b000};
        we    = accept & req_write_i & ~fault & ~rst_i;
    end

    always_comb begin
        rd_raw = '0;
        for (int i = 0; i < 4; i++) begin
            rd_raw[8*i +: 8] = mem_q[{word_idx, 2'(i)}];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (we && be[i]) begin
                mem_q[{word_idx, 2'(i)}] <= wdata[8*i +: 8];
            end
        end
    end

    dmem_load_align u_align (
        .raw_i    (pend_raw_q),
        .size_i   (pend_size_q),
        .off_i    (pend_off_q),
        .signed_i (pend_signed_q),
        .data_o   (aligned)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pend_raw_d    = pend_raw_q;
        pend_size_d   = pend_size_q;
        pend_off_d    = pend_off_q;
        pend_signed_d = pend_signed_q;
        pend_write_d  = pend_write_q;
        pend_err_d    = pend_err_q;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d       = WAIT;
                    cnt_d         = CW'(LATENCY - 1);
                    pend_raw_d    = rd_raw;
                    pend_size_d   = req_size_i;
                    pend_off_d    = addr_i[1:0];
                    pend_signed_d = req_signed_i;
                    pend_write_d  = req_write_i;
                    pend_err_d    = fault;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    rsp_err_d  = pend_err_q;
                    rsp_data_d = (pend_err_q | pend_write_q) ? '0 : aligned;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            pend_raw_q    <= '0;
            pend_size_q   <= SZ_BYTE;
            pend_off_q    <= '0;
            pend_signed_q <= 1'b0;
            pend_write_q  <= 1'b0;
            pend_err_q    <= 1'b0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pend_raw_q    <= pend_raw_d;
            pend_size_q   <= pend_size_d;
            pend_off_q    <= pend_off_d;
            pend_signed_q <= pend_signed_d;
            pend_write_q  <= pend_write_d;
            pend_err_q    <= pend_err_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with LATENCY = 3 and a 1 KiB array.
module tb_dmem_lsu;

    localparam int DEPTH = 1024;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_lsu #(
        .DEPTH_BYTES (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_size_i   (req_size),
        .req_signed_i (req_signed),
        .addr_i       (addr),
        .write_data_i (wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_data_o   (rsp_data),
        .rsp_err_o    (rsp_err)
    );

    task automatic wait_ready();
        int w;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
    endtask

    // Issues one request; lat = edges from accept to the sampled rsp_valid.
    task automatic do_req(
        input  logic        wr,
        input  logic [1:0]  sz,
        input  logic        sg,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        output logic [31:0] d,
        output logic        e,
        output int          lat
    );
        lat = -1;
        d   = 'x;
        e   = 1'bx;
        wait_ready();
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        addr       = a;
        wdata      = wd;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                lat = k;
                d   = rsp_data;
                e   = rsp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (req_ready !== 1'b1) begin
            $display("FAIL reset_ready: got %b want 1", req_ready);
            errors++;
        end
        checks++;
        if (rsp_valid !== 1'b0) begin
            $display("FAIL reset_valid: got %b want 0", rsp_valid);
            errors++;
        end
        checks++;
        if (rsp_data !== 32'h0 || rsp_err !== 1'b0) begin
            $display("FAIL reset_rsp: data=%h err=%b want 0/0",
                     rsp_data, rsp_err);
            errors++;
        end
    endtask

    task automatic test_word();
        logic [31:0] d;
        logic        e;
        int          lat;
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, d, e, lat);
        checks++;
        if (d !== 32'h0 || e !== 1'b0 || lat != LAT) begin
            $display("FAIL store_word: data=%h err=%b lat=%0d want 0/0/%0d",
                     d, e, lat, LAT);
            errors++;
        end
        do_req(1'b1, 2'd2, 1'b0, 32'h14, 32'h12345678, d, e, lat);
        do_req(1'b1, 2'd2, 1'b0, 32'h0, 32'h0, d, e, lat);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, d, e, lat);
        checks++;
        if (d !== 32'hDEADBEEF || e !== 1'b0 || lat != LAT) begin
            $display("FAIL load_word: data=%h err=%b lat=%0d want DEADBEEF/0/%0d",
                     d, e, lat, LAT);
            errors++;
        end
    endtask

    task automatic test_byte_half();
        logic [1:0]  sz [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1};
        logic        sg [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] av [6] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10, 32'h16};
        logic [31:0] ex [6] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD,
                                32'h0000BEEF, 32'hFFFFFFEF, 32'h00001234};
        logic [31:0] d;
        logic        e;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            do_req(1'b0, sz[i], sg[i], av[i], 32'h0, d, e, lat);
            checks++;
            if (d !== ex[i] || e !== 1'b0 || lat != LAT) begin
                $display("FAIL load_sub[%0d]: data=%h err=%b lat=%0d want %h/0/%0d",
                         i, d, e, lat, ex[i], LAT);
                errors++;
            end
        end
    endtask

    task automatic test_byte_store();
        logic [31:0] d;
        logic        e;
        int          lat;
        do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'hAAAAAA55, d, e, lat);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, d, e, lat);
        checks++;
        if (d !== 32'hDEAD55EF || e !== 1'b0) begin
            $display("FAIL byte_store: data=%h err=%b want DEAD55EF/0", d, e);
            errors++;
        end
        do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, d, e, lat);
        checks++;
        if (d !== 32'h12345678) begin
            $display("FAIL byte_store_neigh: data=%h want 12345678", d);
            errors++;
        end
        do_req(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, d, e, lat);
        checks++;
        if (d !== 32'h00000055) begin
            $display("FAIL byte_pos_signed: data=%h want 00000055", d);
            errors++;
        end
        do_req(1'b1, 2'd0, 1'b0, 32'd1023, 32'h000000A5, d, e, lat);
        do_req(1'b0, 2'd0, 1'b1, 32'd1023, 32'h0, d, e, lat);
        checks++;
        if (d !== 32'hFFFFFFA5 || e !== 1'b0) begin
            $display("FAIL last_byte: data=%h err=%b want FFFFFFA5/0", d, e);
            errors++;
        end
    endtask

    task automatic test_faults();
        logic        wr [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [1:0]  sz [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd0};
        logic [31:0] av [6] = '{32'h11, 32'h12, 32'h10, 32'h10,
                                32'd1024, 32'hFFFFFFFF};
        logic [31:0] wv [6] = '{32'h0000FFFF, 32'h0, 32'h0, 32'hFFFFFFFF,
                                32'h11111111, 32'h00000022};
        logic [31:0] d;
        logic        e;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            do_req(wr[i], sz[i], 1'b0, av[i], wv[i], d, e, lat);
            checks++;
            if (d !== 32'h0 || e !== 1'b1 || lat != LAT) begin
                $display("FAIL fault[%0d]: data=%h err=%b lat=%0d want 0/1/%0d",
                         i, d, e, lat, LAT);
                errors++;
            end
            do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, d, e, lat);
            checks++;
            if (d !== 32'hDEAD55EF || e !== 1'b0) begin
                $display("FAIL fault_mem[%0d]: data=%h err=%b want DEAD55EF/0",
                         i, d, e);
                errors++;
            end
        end
        do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, d, e, lat);
        checks++;
        if (d !== 32'h0) begin
            $display("FAIL fault_alias0: data=%h want 00000000", d);
            errors++;
        end
        do_req(1'b0, 2'd0, 1'b0, 32'd1023, 32'h0, d, e, lat);
        checks++;
        if (d !== 32'h000000A5) begin
            $display("FAIL fault_alias1023: data=%h want 000000A5", d);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic exp_rdy;
        logic exp_vld;
        wait_ready();
        req_write  = 1'b0;
        req_size   = 2'd2;
        req_signed = 1'b0;
        addr       = 32'h10;
        req_valid  = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (n > 0) @(negedge clk);
            exp_rdy = (n % (LAT + 2) == 0);
            exp_vld = (n % (LAT + 2) == LAT + 1);
            checks++;
            if (req_ready !== exp_rdy || rsp_valid !== exp_vld ||
                (exp_vld && rsp_data !== 32'hDEAD55EF)) begin
                $display("FAIL b2b[%0d]: ready=%b valid=%b data=%h want %b/%b/DEAD55EF",
                         n, req_ready, rsp_valid, rsp_data, exp_rdy, exp_vld);
                errors++;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic        e;
        int          lat;
        int          pulses;
        wait_ready();
        req_write = 1'b1;
        req_size  = 2'd2;
        addr      = 32'h20;
        wdata     = 32'hCAFEF00D;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            $display("FAIL rst_mid_state: ready=%b valid=%b want 1/0",
                     req_ready, rsp_valid);
            errors++;
        end
        checks++;
        if (rsp_data !== 32'h0 || rsp_err !== 1'b0) begin
            $display("FAIL rst_mid_rsp: data=%h err=%b want 0/0",
                     rsp_data, rsp_err);
            errors++;
        end
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            $display("FAIL rst_mid_pulse: pulses=%0d want 0", pulses);
            errors++;
        end
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, d, e, lat);
        checks++;
        if (d !== 32'hCAFEF00D || e !== 1'b0 || lat != LAT) begin
            $display("FAIL rst_mid_store: data=%h err=%b lat=%0d want CAFEF00D/0/%0d",
                     d, e, lat, LAT);
            errors++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_word();
        test_byte_half();
        test_byte_store();
        test_faults();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised byte-addressed data memory with a valid/ready request port, byte/half/word load-store sizing, signed or unsigned load extension, configurable response latency and alignment/range fault reporting. Sits in the MEM stage of the CPU datapath as the next-generation data memory. One request is outstanding at a time; every accepted request produces exactly one response.

## Interface
- DEPTH_BYTES, 1024: memory size in bytes; power of two, ≥ 4.
- LATENCY, 1: cycles from the accept edge to `rsp_valid_o`; ≥ 1.
- clk_i  in  1  clock, all logic on the rising edge.
- rst_i  in  1  reset; one clock; reset is synchronous and active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  block can accept; a request is accepted when `req_valid_i & req_ready_o` at a rising edge.
- req_write_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_signed_i  in  1  load sign-extends when 1; ignored for stores and words.
- addr_i  in  32  byte address.
- write_data_i  in  32  store data, taken from the low bytes (byte: [7:0], half: [15:0]).
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_data_o  out  32  load result; 0 for stores and faults.
- rsp_err_o  out  1  request faulted; valid with `rsp_valid_o`.

## Operation
- Storage: DEPTH_BYTES × 8-bit array, little-endian (byte at addr holds bits [7:0]). Contents are not reset.
- FSM states:
  - IDLE: `req_ready_o` = 1. Accept → WAIT with counter = LATENCY−1.
  - WAIT: `req_ready_o` = 0. When the counter is 0, register the response and go to RESP; otherwise decrement.
  - RESP: `rsp_valid_o` = 1 for this cycle only, `req_ready_o` = 0 → IDLE.
- Fault conditions, evaluated at accept:
  - `req_size_i` = 3.
  - Half with addr[0] = 1.
  - Word with addr[1:0] ≠ 0.
  - `addr_i` ≥ DEPTH_BYTES.
- On fault: no array write, `rsp_err_o` = 1, `rsp_data_o` = 0.
- Stores: bytes are written at the accept edge. Response: data 0, err 0.
- Loads: bytes are read at the accept edge and held in a response register.
  - Byte: bits [7:0] = mem[a].
  - Half: bits [15:0] = {mem[a+1], mem[a]}.
  - Word: all 4 bytes.
  - Upper bits are zero-filled, or copies of the top loaded bit when `req_signed_i` = 1.
- No response backpressure: the consumer must take the response in the RESP cycle.

## Timing
- Accept at edge T. `rsp_valid_o` is high in the cycle following edge T+LATENCY. `req_ready_o` is high again after edge T+LATENCY+1. Throughput is one request per LATENCY+2 cycles.
- A load accepted after a store to the same address returns the stored data, because the store commits at its own accept edge.
- Reset values: state IDLE, `req_ready_o` 1 (combinational from state), `rsp_valid_o` 0, `rsp_data_o` 0, `rsp_err_o` 0, counter 0.
- Reset mid-operation: the pending response is dropped and no `rsp_valid_o` pulse occurs. A store accepted before reset stays committed.
- `req_valid_i` while not ready: ignored, nothing is latched. The requester must hold the request until it is accepted.
- Response outputs hold their last value outside RESP. Only `rsp_valid_o` qualifies them.

## Structure
- Package `dmem_pkg`:
  - Size encodings SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2.
  - FSM state enum {IDLE, WAIT, RESP}.
  - Function for the alignment/fault check.
- Sub-module `dmem_load_align`: combinational extraction and sign/zero extension of 4 raw bytes, given size, addr[1:0] and signed. It is reused by the future cache refill path.
- Counter width: $clog2(LATENCY) + 1.

## Test plan
- Reset, then store word 0xDEADBEEF @0x10 and load word @0x10 → responses err 0, load data 0xDEADBEEF. LATENCY = 3 gives `rsp_valid_o` exactly in the cycle after edge T+3.
- Load byte @0x13 with signed = 1 → 0xFFFFFFDE; unsigned → 0x000000DE. Load half @0x12 with signed = 1 → 0xFFFFDEAD.
- Store byte 0x55 @0x11, then load word @0x10 → 0xDEAD55EF. No other byte changes.
- Faults → err 1, data 0, and a following load @0x10 shows memory unchanged:
  - half store @0x11,
  - word load @0x12,
  - size 3,
  - addr = DEPTH_BYTES.
- `req_valid_i` held high continuously → exactly one accept per LATENCY+2 cycles. `req_ready_o` is low from accept until after RESP.
- `rst_i` pulsed while in WAIT → no `rsp_valid_o` pulse, `req_ready_o` = 1 the cycle after reset, and the store accepted before reset reads back.
